// File: rtl/crypt_sequencer.sv
// -----------------------------------------------------------------------------
// crypt_sequencer
//
// Golden hardware reference for the LFSR message-encryption program. Once
// launched through the req/ack handshake it reads three configuration bytes
// (pre_length, pattern number, LFSR seed) and the message from data memory,
// builds a 64-byte space-padded frame and writes each byte, XORed with a 7-bit
// LFSR and carrying even parity in bit 7, to OUT_BASE..OUT_BASE+63.
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   init       in   asynchronous active-high reset
//   req        in   high holds idle; a high-to-low transition launches a run
//   ack        out  run complete, held until req is sampled high
//   busy       out  high from launch until ack rises
//   cfg_err    out  pattern number low nibble was above 8 (default taps used)
//   dm_addr    out  data memory address
//   dm_wr_en   out  data memory write strobe
//   dm_wr_data out  data memory write data
//   dm_rd_data in   data memory read data, combinational from dm_addr
//
// Every byte costs exactly one RD and one WR cycle, padding included, so a run
// always takes 131 cycles from the launching edge to ack.
// -----------------------------------------------------------------------------
module crypt_sequencer #(
    parameter int unsigned MSG_BASE  = 0,
    parameter int unsigned CFG_BASE  = 61,
    parameter int unsigned OUT_BASE  = 64,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned MAX_MSG   = 49
) (
    input  logic       clk,
    input  logic       init,
    input  logic       req,
    output logic       ack,
    output logic       busy,
    output logic       cfg_err,
    output logic [7:0] dm_addr,
    output logic       dm_wr_en,
    output logic [7:0] dm_wr_data,
    input  logic [7:0] dm_rd_data
);

    localparam logic [7:0] MSG_BASE_B = 8'(MSG_BASE);
    localparam logic [7:0] CFG_BASE_B = 8'(CFG_BASE);
    localparam logic [7:0] OUT_BASE_B = 8'(OUT_BASE);
    localparam logic [7:0] MAX_MSG_B  = 8'(MAX_MSG);
    localparam logic [5:0] LAST_IDX   = 6'(FRAME_LEN - 1);
    localparam logic [7:0] SPACE      = 8'h20;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_PRE  = 3'd1,
        LD_PTN  = 3'd2,
        LD_INIT = 3'd3,
        RD      = 3'd4,
        WR      = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t     state_r;
    logic       req_d_r;
    logic       armed_r;     // req has been seen high since reset
    logic [7:0] pre_r;
    logic [6:0] ptn_r;
    logic [6:0] lfsr_r;
    logic [5:0] idx_r;
    logic [7:0] msg_idx_r;
    logic       msg_end_r;

    logic       pad_s;
    logic [7:0] plain_s;

    // Feedback tap mask for a pattern number; out-of-range falls back to 0x60.
    function automatic logic [6:0] tap_lookup(input logic [3:0] sel);
        logic [6:0] taps;
        case (sel)
            4'd0:    taps = 7'h60;
            4'd1:    taps = 7'h48;
            4'd2:    taps = 7'h78;
            4'd3:    taps = 7'h72;
            4'd4:    taps = 7'h6A;
            4'd5:    taps = 7'h69;
            4'd6:    taps = 7'h5C;
            4'd7:    taps = 7'h7E;
            4'd8:    taps = 7'h7B;
            default: taps = 7'h60;
        endcase
        return taps;
    endfunction

    // Even parity over the seven data bits.
    function automatic logic parity7(input logic [6:0] v);
        return ^v;
    endfunction

    // Encrypt one plaintext byte and place parity of the result in bit 7.
    function automatic logic [7:0] seal_byte(input logic [7:0] plain,
                                             input logic [6:0] key);
        logic [7:0] c;
        c = plain ^ {1'b0, key};
        return {parity7(c[6:0]), c[6:0]};
    endfunction

    // True when the frame byte at position i is padding rather than message.
    function automatic logic is_pad(input logic [5:0] i, input logic [7:0] mi,
                                    input logic me, input logic [7:0] pre);
        return ({2'b00, i} < pre) || me || (mi >= MAX_MSG_B);
    endfunction

    // Address presented during RD; padding bytes park the bus on MSG_BASE.
    function automatic logic [7:0] rd_addr(input logic [5:0] i, input logic [7:0] mi,
                                           input logic me, input logic [7:0] pre);
        logic [7:0] a;
        if (is_pad(i, mi, me, pre)) begin
            a = MSG_BASE_B;
        end else begin
            a = MSG_BASE_B + mi;
        end
        return a;
    endfunction

    // Plaintext for the byte being read: message character or a space.
    always_comb begin
        pad_s   = is_pad(idx_r, msg_idx_r, msg_end_r, pre_r);
        plain_s = SPACE;
        if (pad_s || (dm_rd_data == 8'h00)) begin
            plain_s = SPACE;
        end else begin
            plain_s = dm_rd_data;
        end
    end

    // Sequencer FSM; memory-side outputs are registered one state ahead so
    // they are valid for the whole cycle of the state that uses them.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_r    <= IDLE;
            req_d_r    <= 1'b1;
            armed_r    <= 1'b0;
            pre_r      <= 8'h00;
            ptn_r      <= 7'h00;
            lfsr_r     <= 7'h00;
            idx_r      <= 6'd0;
            msg_idx_r  <= 8'h00;
            msg_end_r  <= 1'b0;
            ack        <= 1'b0;
            busy       <= 1'b0;
            cfg_err    <= 1'b0;
            dm_addr    <= 8'h00;
            dm_wr_en   <= 1'b0;
            dm_wr_data <= 8'h00;
        end else begin
            req_d_r <= req;
            if (req) begin
                armed_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    // A req held low straight out of reset is not a launch.
                    if (armed_r && req_d_r && !req) begin
                        state_r   <= LD_PRE;
                        busy      <= 1'b1;
                        dm_addr   <= CFG_BASE_B;
                        idx_r     <= 6'd0;
                        msg_idx_r <= 8'h00;
                        msg_end_r <= 1'b0;
                    end
                end
                LD_PRE: begin
                    pre_r   <= dm_rd_data;
                    dm_addr <= CFG_BASE_B + 8'd1;
                    state_r <= LD_PTN;
                end
                LD_PTN: begin
                    ptn_r   <= tap_lookup(dm_rd_data[3:0]);
                    cfg_err <= (dm_rd_data[3:0] > 4'd8);
                    dm_addr <= CFG_BASE_B + 8'd2;
                    state_r <= LD_INIT;
                end
                LD_INIT: begin
                    // An all-zero seed would lock the LFSR, so substitute 1.
                    if (dm_rd_data[6:0] == 7'h00) begin
                        lfsr_r <= 7'h01;
                    end else begin
                        lfsr_r <= dm_rd_data[6:0];
                    end
                    dm_addr <= rd_addr(6'd0, 8'h00, 1'b0, pre_r);
                    state_r <= RD;
                end
                RD: begin
                    if (!pad_s) begin
                        if (dm_rd_data == 8'h00) begin
                            msg_end_r <= 1'b1;
                        end else begin
                            msg_idx_r <= msg_idx_r + 8'd1;
                        end
                    end
                    dm_wr_data <= seal_byte(plain_s, lfsr_r);
                    dm_wr_en   <= 1'b1;
                    dm_addr    <= OUT_BASE_B + {2'b00, idx_r};
                    state_r    <= WR;
                end
                WR: begin
                    dm_wr_en <= 1'b0;
                    lfsr_r   <= {lfsr_r[5:0], ^(lfsr_r & ptn_r)};
                    idx_r    <= idx_r + 6'd1;
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
                        ack     <= 1'b1;
                        busy    <= 1'b0;
                        dm_addr <= 8'h00;
                    end else begin
                        state_r <= RD;
                        dm_addr <= rd_addr(idx_r + 6'd1, msg_idx_r, msg_end_r, pre_r);
                    end
                end
                DONE: begin
                    if (req) begin
                        state_r <= IDLE;
                        ack     <= 1'b0;
                        cfg_err <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ack      <= 1'b0;
                    busy     <= 1'b0;
                    dm_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypt_sequencer.sv
module tb_crypt_sequencer;

    logic       clk = 1'b0;
    logic       init;
    logic       req;
    logic       ack;
    logic       busy;
    logic       cfg_err;
    logic [7:0] dm_addr;
    logic       dm_wr_en;
    logic [7:0] dm_wr_data;
    logic [7:0] dm_rd_data;

    logic [7:0] mem [0:255];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t sq[$];
    wr_t exp_w;
    int  n_vec  = 0;
    int  n_err  = 0;
    int  bad_rd = 0;

    logic [7:0] exp_frame [0:63];
    logic [7:0] ref_a     [0:63];

    localparam logic [6:0] TAPS [0:8] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                          7'h69, 7'h5C, 7'h7E, 7'h7B};

    crypt_sequencer dut (
        .clk        (clk),
        .init       (init),
        .req        (req),
        .ack        (ack),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .dm_addr    (dm_addr),
        .dm_wr_en   (dm_wr_en),
        .dm_wr_data (dm_wr_data),
        .dm_rd_data (dm_rd_data)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    assign dm_rd_data = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_wr_en) mem[dm_addr] <= dm_wr_data;
    end

    // Monitor: every write strobe pops and checks the next expected write.
    always @(negedge clk) begin
        if (dm_wr_en) begin
            n_vec++;
            if (sq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr=%02h data=%02h, no write expected",
                         dm_addr, dm_wr_data);
            end else begin
                exp_w = sq.pop_front();
                if ({dm_addr, dm_wr_data} !== {exp_w.addr, exp_w.data}) begin
                    n_err++;
                    $display("FAIL write: got addr=%02h data=%02h, expected addr=%02h data=%02h",
                             dm_addr, dm_wr_data, exp_w.addr, exp_w.data);
                end
            end
        end
        if (busy && !dm_wr_en && dm_addr >= 8'd49 && dm_addr <= 8'd60) bad_rd++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Load memory: message (or generated filler), config bytes, clear output.
    task automatic setup(input logic [7:0] pre, input logic [7:0] pt, input logic [7:0] li,
                         input string msg, input int fill_n);
        for (int k = 0; k < 61; k++) mem[k] = 8'h00;
        for (int k = 0; k < msg.len(); k++) mem[k] = msg[k];
        for (int k = 0; k < fill_n; k++) mem[k] = 8'h41 + 8'(k % 26);
        mem[61] = pre;
        mem[62] = pt;
        mem[63] = li;
        for (int k = 64; k < 128; k++) mem[k] = 8'hFF;
    endtask

    // Reference model of the encrypted frame built from the memory image.
    task automatic model_frame();
        logic [6:0] tap;
        logic [6:0] l;
        logic [7:0] p;
        logic [7:0] c;
        logic [3:0] sel;
        int mi;
        bit ended;
        sel = mem[62][3:0];
        tap = (sel <= 4'd8) ? TAPS[sel] : 7'h60;
        l = mem[63][6:0];
        if (l == 7'h00) l = 7'h01;
        mi = 0;
        ended = 0;
        for (int i = 0; i < 64; i++) begin
            if (i < mem[61] || ended || mi >= 49) p = 8'h20;
            else if (mem[mi] == 8'h00) begin
                ended = 1;
                p = 8'h20;
            end else begin
                p = mem[mi];
                mi++;
            end
            c = p ^ {1'b0, l};
            c[7] = ^c[6:0];
            exp_frame[i] = c;
            l = {l[5:0], ^(l & tap)};
        end
    endtask

    task automatic compare_frame(input string name);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s[%0d]", name, i), mem[64+i], ref_a[i]);
    endtask

    // Launch one run and follow it to ack (or abort it with init).
    task automatic do_run(input bit exp_cfg, input int abort_at, input bit toggle);
        int cyc;
        bit done;
        model_frame();
        for (int i = 0; i < 64; i++) sq.push_back({8'(64 + i), exp_frame[i]});
        req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk);                       // E0
        cyc = 0;
        done = 0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) check("cfg_err_E3", cfg_err, exp_cfg);
            if (toggle && cyc >= 20 && cyc < 30) req = ~req;
            if (cyc == abort_at) begin
                init = 1'b1;
                sq.delete();
                @(negedge clk);
                init = 1'b0;
                repeat (150) @(posedge clk);
                #1;
                check("abort_ack", ack, 1'b0);
                check("abort_busy", busy, 1'b0);
                return;
            end
            if (ack) done = 1;
        end
        check("latency", cyc, 131);
        check("busy_at_ack", busy, 1'b0);
        check("all_written", sq.size(), 0);
        sq.delete();
        req = 1'b1;
        @(posedge clk); #1;
        check("ack_fall", ack, 1'b0);
        check("cfg_err_clear", cfg_err, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        init = 1'b1;
        req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_wr_en", dm_wr_en, 1'b0);
        check("rst_addr", dm_addr, 8'h00);
        check("rst_wr_data", dm_wr_data, 8'h00);
        init = 1'b0;

        // req held low out of reset must not start a run
        repeat (10) @(posedge clk);
        #1;
        check("held_low_ack", ack, 1'b0);
        check("held_low_busy", busy, 1'b0);

        // Run A: pre=10, pattern 0, seed 1, "Mr."
        setup(8'd10, 8'h00, 8'h01, "Mr.", 0);
        do_run(1'b0, -1, 1'b0);
        for (int i = 0; i < 64; i++) ref_a[i] = exp_frame[i];
        check("A_byte0", mem[64], 8'h21);
        check("A_byte1", mem[65], 8'h22);
        check("A_byte2", mem[66], 8'h24);
        check("A_byte10", mem[74], 8'h55);

        // Same config with req toggling mid-run
        setup(8'd10, 8'h00, 8'h01, "Mr.", 0);
        do_run(1'b0, -1, 1'b1);
        compare_frame("toggle");

        // Seed 0 behaves as seed 1
        setup(8'd10, 8'h00, 8'h00, "Mr.", 0);
        do_run(1'b0, -1, 1'b0);
        compare_frame("seed0");

        // Out-of-range pattern falls back to pattern 0 and flags cfg_err
        setup(8'd10, 8'h0C, 8'h01, "Mr.", 0);
        do_run(1'b1, -1, 1'b0);
        compare_frame("bad_ptn");

        // 60-character message clipped to 49, upper nibble of pt_no ignored
        setup(8'd15, 8'h35, 8'hDA, "", 60);
        bad_rd = 0;
        do_run(1'b0, -1, 1'b0);
        check("no_rd_49_60", bad_rd, 0);

        // pre beyond the frame: all spaces; seed bit 7 ignored
        setup(8'd200, 8'h02, 8'hD5, "Hi", 0);
        do_run(1'b0, -1, 1'b0);
        check("E_byte0", mem[64], 8'hF5);

        // Abort at E40: bytes 0..17 written, byte 18 untouched
        setup(8'd10, 8'h00, 8'h01, "Mr.", 0);
        do_run(1'b0, 40, 1'b0);
        check("abort_byte17", mem[81], ref_a[17]);
        check("abort_byte18", mem[82], 8'hFF);

        // Relaunch after the abort rewrites the whole frame
        setup(8'd10, 8'h00, 8'h01, "Mr.", 0);
        do_run(1'b0, -1, 1'b0);
        compare_frame("relaunch");

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/crypt_sequencer.md
# crypt_sequencer

Hardware sequencer for the Program #1 LFSR message-encryption datapath. It sits beside the data memory (`DM`) in `top_level` and uses the same `req`/`ack` launch protocol as the CPU. When launched, it reads the configuration bytes and message from `DM`, forms the 64-byte space-padded frame, and encrypts each byte with a 7-bit LFSR. Each output byte gets a parity bit in its MSB and is written to `DM[64..127]`. It serves as the golden hardware reference that CPU program results are compared against.

## Interface
Parameters:
- MSG_BASE, 0, `DM` address of message byte 0
- CFG_BASE, 61, address of pre_length; pt_no is at CFG_BASE+1 and LFSR_init at CFG_BASE+2
- OUT_BASE, 64, address of encrypted byte 0
- FRAME_LEN, 64, number of output bytes
- MAX_MSG, 49, message clip length

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- init  in  1  reset, asynchronous and active-high
- req  in  1  high holds the block idle; a high-to-low transition launches a run
- ack  out  1  run complete; stays high until req returns high
- busy  out  1  high from launch until ack rises
- cfg_err  out  1  latched when pt_no[3:0] > 8
- dm_addr  out  8  `DM` address
- dm_wr_en  out  1  `DM` write strobe; memory writes on the clk edge while this is high
- dm_wr_data  out  8  write data
- dm_rd_data  in  8  `DM` read data, combinational from dm_addr in the same cycle

## Operation
- States: IDLE, LD_PRE, LD_PTN, LD_INIT, RD, WR, DONE.
- Reset: state=IDLE, all outputs 0, req_d (registered previous req) = 1. Registers cleared: pre, ptn, lfsr, idx (6-bit), msg_idx, msg_end.
- IDLE → LD_PRE when req_d=1 and req=0. A req that is held low after reset never launches a run.
- LD_PRE, LD_PTN and LD_INIT each take one cycle. dm_addr is CFG_BASE, CFG_BASE+1 and CFG_BASE+2 respectively. dm_rd_data is latched at the end of each state.
- Pattern selection:
  - pt_no[3:0] 0..8 selects 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E, 0x7B in that order.
  - Any other value selects 0x60 and sets cfg_err. pt_no[7:4] is ignored.
- LFSR_init: bit 7 is ignored. A value of 0 is replaced by 7'h01.
- RD state (byte idx):
  - If idx < pre, or msg_end=1, or msg_idx ≥ MAX_MSG: plain = 0x20, and no memory read is used (dm_addr is don't-care, drive MSG_BASE).
  - Otherwise dm_addr = MSG_BASE+msg_idx. A value of 0x00 sets msg_end and gives plain = 0x20. Any other value gives plain = dm_rd_data and increments msg_idx.
- pre is compared as an 8-bit unsigned value. pre ≥ 64 makes the whole frame spaces.
- WR state:
  - c = plain ^ {1'b0, lfsr}, then c[7] = ^c[6:0].
  - dm_addr = OUT_BASE+idx, dm_wr_en = 1, dm_wr_data = c.
  - lfsr ← {lfsr[5:0], ^(lfsr & ptn)}.
  - idx increments; after idx = 63 go to DONE, otherwise go to RD.
- DONE: ack = 1, busy = 0. Go to IDLE, clearing ack and cfg_err, once req samples 1.
- req changes during LD_* states, RD or WR are ignored.
- init asserted mid-run: return to IDLE immediately. Bytes already written stay in `DM`; no further writes happen.

## Timing
- Every byte uses two cycles, RD then WR, including pad bytes, so latency is deterministic.
- With E0 = the edge that samples the falling req:
  - Config bytes are latched at E1, E2 and E3.
  - Byte i is written at edge E(5+2i).
  - ack and busy=0 become visible after E131.
- Latency from launch to ack is 131 cycles, independent of the data.
- dm_wr_en is high only in WR, 64 single-cycle pulses per run.
- ack falls one cycle after req is sampled high.

## Test plan
- Config pre=10, pt_no=0, LFSR_init=0x01, message "Mr." → DM[64]=0x21, DM[65]=0x22, DM[66]=0x24. Byte 10 equals ('M'^lfsr10) with parity. All 64 bytes match the software model, and ack rises 131 cycles after E0.
- LFSR_init=0x00 → output bytes identical to those with LFSR_init=0x01.
- pt_no=0x0C → cfg_err=1 by E3, and output identical to pt_no=0. cfg_err clears after req goes high.
- Message of 60 non-zero bytes with pre=15 → only the first 49 characters are encrypted. Bytes 64..127 = the 49-char frame, and no reads from addresses ≥ 49.
- init pulsed at E40 → no dm_wr_en after reset, and ack stays 0. A following launch rewrites all 64 bytes correctly.
- req held low from reset → no run and ack=0. req high for 1 cycle then low → a run starts. During the run, req toggling is ignored and output is unchanged.
